// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
//
// Contents:
//   state_t      frame sequencer state encoding
//   PARITY_EVEN  parity_type value selecting even parity
//   PARITY_ODD   parity_type value selecting odd parity
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO holding words waiting to be serialised.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request and data (ignored while full)
//   pop, dout     read request (ignored while empty); dout shows the head word
//   full, empty   occupancy flags
//   level         number of stored words, 0..DEPTH
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
   // the natural overflow the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_txq.sv
// UART transmitter fed by a small word queue.
//
// Build option: define UART_TXQ_PARITY_EN to include the parity bit stage;
// without it parity_enable/parity_type are ignored and frames go DATA -> STOP.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   P_DATA          word to queue, pushed when Data_Valid & ready
//   ready           queue not full (combinational)
//   Prescale        clock cycles per bit, 0 behaves as 1
//   parity_enable   add a parity bit (parity build only)
//   parity_type     0 even, 1 odd (parity build only)
//   stop_bits       0 one stop bit, 1 two stop bits
//   TX_OUT          serial line, idle high
//   busy            a frame is on the line
//   fifo_level      queued word count
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | one or two stop bits (high)
module uart_txq
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [DATA_WIDTH-1:0]         P_DATA,
   input  logic                          Data_Valid,
   output logic                          ready,
   input  logic [PRESCALE_WIDTH-1:0]     Prescale,
   input  logic                          parity_enable,
   input  logic                          parity_type,
   input  logic                          stop_bits,
   output logic                          TX_OUT,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   state_t                    state;
   logic [PRESCALE_WIDTH-1:0] presc_l;
   logic [PRESCALE_WIDTH-1:0] bit_cnt;
   logic [BW-1:0]             bit_idx;
   logic [DATA_WIDTH-1:0]     shreg;
   logic                      stop2_l;
   logic                      stop_idx;
   logic                      full;
   logic                      empty;
   logic [DATA_WIDTH-1:0]     head;
   logic                      bit_done;
   logic                      last_stop;
   logic                      pop;

`ifdef UART_TXQ_PARITY_EN
   logic par_en_l;
   logic par_bit;
`else
   logic unused_parity;
   assign unused_parity = parity_enable ^ parity_type;
`endif

   // Bit-period down-counter reload: a bit lasts max(p,1) cycles.
   function automatic logic [PRESCALE_WIDTH-1:0] period_load(input logic [PRESCALE_WIDTH-1:0] p);
      return (p == '0) ? '0 : p - PRESCALE_WIDTH'(1);
   endfunction

   assign ready     = ~full;
   assign bit_done  = (bit_cnt == '0);
   assign last_stop = (state == STOP) && bit_done && (!stop2_l || stop_idx);
   // Pop from IDLE, or straight out of the final stop bit so frames abut.
   assign pop       = !empty && ((state == IDLE) || last_stop);

   uart_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (Data_Valid),
      .din   (P_DATA),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         TX_OUT   <= 1'b1;
         busy     <= 1'b0;
         presc_l  <= '0;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         stop2_l  <= 1'b0;
         stop_idx <= 1'b0;
`ifdef UART_TXQ_PARITY_EN
         par_en_l <= 1'b0;
         par_bit  <= 1'b0;
`endif
      end else if (pop) begin
         // Frame configuration is captured here and held for the whole frame.
         state    <= START;
         TX_OUT   <= 1'b0;
         busy     <= 1'b1;
         presc_l  <= Prescale;
         bit_cnt  <= period_load(Prescale);
         bit_idx  <= '0;
         shreg    <= head;
         stop2_l  <= stop_bits;
         stop_idx <= 1'b0;
`ifdef UART_TXQ_PARITY_EN
         par_en_l <= parity_enable;
         par_bit  <= (^head) ^ (parity_type == PARITY_ODD);
`endif
      end else if ((state != IDLE) && !bit_done) begin
         bit_cnt <= bit_cnt - PRESCALE_WIDTH'(1);
      end else begin
         case (state)
            START: begin
               state   <= DATA;
               TX_OUT  <= shreg[0];
               shreg   <= shreg >> 1;
               bit_cnt <= period_load(presc_l);
            end
            DATA: begin
               bit_cnt <= period_load(presc_l);
               if (bit_idx == LAST_BIT) begin
`ifdef UART_TXQ_PARITY_EN
                  if (par_en_l) begin
                     state  <= PARITY;
                     TX_OUT <= par_bit;
                  end else begin
                     state  <= STOP;
                     TX_OUT <= 1'b1;
                  end
`else
                  state  <= STOP;
                  TX_OUT <= 1'b1;
`endif
               end else begin
                  bit_idx <= bit_idx + BW'(1);
                  TX_OUT  <= shreg[0];
                  shreg   <= shreg >> 1;
               end
            end
`ifdef UART_TXQ_PARITY_EN
            PARITY: begin
               state   <= STOP;
               TX_OUT  <= 1'b1;
               bit_cnt <= period_load(presc_l);
            end
`endif
            STOP: begin
               if (!stop2_l || stop_idx) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  TX_OUT <= 1'b1;
               end else begin
                  stop_idx <= 1'b1;
                  bit_cnt  <= period_load(presc_l);
               end
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_txq.sv
// Directed self-checking bench for uart_txq (default parameters).
// Line activity is logged on the falling edge and compared bit by bit
// against frames built from hand-chosen words.
module tb_uart_txq;

`ifdef UART_TXQ_PARITY_EN
   localparam logic PAR_BUILD = 1'b1;
`else
   localparam logic PAR_BUILD = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       ready;
   logic [5:0] Prescale;
   logic       parity_enable;
   logic       parity_type;
   logic       stop_bits;
   logic       TX_OUT;
   logic       busy;
   logic [2:0] fifo_level;

   int errors = 0;
   int checks = 0;

   uart_txq #(
      .DATA_WIDTH     (8),
      .FIFO_DEPTH     (4),
      .PRESCALE_WIDTH (6)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .P_DATA        (P_DATA),
      .Data_Valid    (Data_Valid),
      .ready         (ready),
      .Prescale      (Prescale),
      .parity_enable (parity_enable),
      .parity_type   (parity_type),
      .stop_bits     (stop_bits),
      .TX_OUT        (TX_OUT),
      .busy          (busy),
      .fifo_level    (fifo_level)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1);
   end

   logic       rec = 1'b0;
   logic [1:0] log_q[$];
   always @(negedge CLK) if (rec) log_q.push_back({busy, TX_OUT});

   typedef struct {logic v; int per;} ebit_t;
   ebit_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      P_DATA     = d;
      Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
   endtask

   task automatic add_bit(input logic v, input int per);
      ebit_t e;
      e.v = v;
      e.per = per;
      exp_q.push_back(e);
   endtask

   task automatic add_frame(input logic [7:0] d, input logic par_on, input logic par,
                            input logic stop2, input int per);
      add_bit(1'b0, per);
      for (int i = 0; i < 8; i++) add_bit(d[i], per);
      if (par_on) add_bit(par, per);
      add_bit(1'b1, per);
      if (stop2) add_bit(1'b1, per);
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      logic done = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy && fifo_level == 3'd0) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      check({tag, "_idle_reached"}, done, 1);
      tick();
      tick();
   endtask

   // Compare the log, from its first low sample, with the expected bit list.
   task automatic check_log(input string tag);
      int   s = -1;
      int   idx;
      logic busy_ok = 1'b1;
      for (int i = 0; i < log_q.size(); i++) begin
         if (log_q[i][0] == 1'b0) begin
            s = i;
            break;
         end
      end
      check({tag, "_start_seen"}, (s >= 0), 1);
      if (s < 0) s = log_q.size();
      idx = s;
      for (int k = 0; k < exp_q.size(); k++) begin
         logic [31:0] got = '0;
         logic [31:0] want;
         want = exp_q[k].v ? ((32'd1 << exp_q[k].per) - 32'd1) : 32'd0;
         for (int c = 0; c < exp_q[k].per; c++) begin
            if (idx < log_q.size()) begin
               got[c] = log_q[idx][0];
               if (!log_q[idx][1]) busy_ok = 1'b0;
            end else begin
               got[c] = 1'bx;
            end
            idx++;
         end
         check($sformatf("%s_bit%0d", tag, k), got, want);
      end
      check({tag, "_busy_held"}, busy_ok, 1);
      check({tag, "_idle_after"}, (idx < log_q.size()) ? log_q[idx] : 2'bxx, 2'b01);
      exp_q.delete();
      log_q.delete();
   endtask

   logic [7:0] qw [5];

   initial begin
      int nb;
      int nz;
      RST           = 1'b1;
      Data_Valid    = 1'b0;
      P_DATA        = '0;
      Prescale      = 6'd4;
      parity_enable = 1'b0;
      parity_type   = 1'b0;
      stop_bits     = 1'b0;
      tick();
      tick();
      check("reset_tx", TX_OUT, 1);
      check("reset_busy", busy, 0);
      check("reset_level", fifo_level, 0);
      check("reset_ready", ready, 1);
      RST = 1'b0;
      tick();

      // A5 at 4 cycles/bit, two-edge latency, busy for 10 bits x 4
      rec = 1'b1;
      P_DATA     = 8'hA5;
      Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
      check("lat_edge1_tx", TX_OUT, 1);
      check("lat_edge1_level", fifo_level, 1);
      tick();
      check("lat_edge2_tx", TX_OUT, 0);
      check("lat_edge2_busy", busy, 1);
      check("lat_edge2_level", fifo_level, 0);
      wait_idle("a5", 200);
      nb = 0;
      foreach (log_q[i]) if (log_q[i][1]) nb++;
      check("a5_busy_cycles", nb, 40);
      add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 4);
      check_log("a5");

      // parity on word 03: odd -> 1, even -> 0 (no parity bit without the option)
      Prescale      = 6'd2;
      parity_enable = 1'b1;
      parity_type   = 1'b1;
      push(8'h03);
      wait_idle("par_odd", 200);
      add_frame(8'h03, PAR_BUILD, 1'b1, 1'b0, 2);
      check_log("par_odd");
      parity_type = 1'b0;
      push(8'h03);
      wait_idle("par_even", 200);
      add_frame(8'h03, PAR_BUILD, 1'b0, 1'b0, 2);
      check_log("par_even");
      parity_enable = 1'b0;

      // fill the queue while the first frame is on the line; fifth push refused
      qw[0] = 8'h22; qw[1] = 8'h3C; qw[2] = 8'h81; qw[3] = 8'h5A; qw[4] = 8'hFF;
      push(8'h11);
      tick();
      check("q_level_after_pop", fifo_level, 0);
      check("q_busy", busy, 1);
      for (int k = 0; k < 5; k++) begin
         P_DATA     = qw[k];
         Data_Valid = 1'b1;
         check($sformatf("q_ready_before_push%0d", k), ready, (k < 4) ? 1 : 0);
         if (k == 4) check("q_level_full", fifo_level, 4);
         tick();
      end
      Data_Valid = 1'b0;
      check("q_level_after_drop", fifo_level, 4);
      wait_idle("queue", 600);
      add_frame(8'h11, 1'b0, 1'b0, 1'b0, 2);
      add_frame(8'h22, 1'b0, 1'b0, 1'b0, 2);
      add_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2);
      add_frame(8'h81, 1'b0, 1'b0, 1'b0, 2);
      add_frame(8'h5A, 1'b0, 1'b0, 1'b0, 2);
      check_log("queue");

      // Prescale=0 behaves as 1; two stop bits before the next start
      Prescale   = 6'd0;
      stop_bits  = 1'b1;
      P_DATA     = 8'h96;
      Data_Valid = 1'b1;
      tick();
      P_DATA     = 8'h0F;
      tick();
      Data_Valid = 1'b0;
      check("simul_push_pop_level", fifo_level, 1);
      wait_idle("fast", 200);
      add_frame(8'h96, 1'b0, 1'b0, 1'b1, 1);
      add_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1);
      check_log("fast");

      // configuration change mid-frame applies only to the next frame
      Prescale   = 6'd4;
      stop_bits  = 1'b0;
      P_DATA     = 8'hC3;
      Data_Valid = 1'b1;
      tick();
      P_DATA     = 8'h5A;
      tick();
      Data_Valid = 1'b0;
      repeat (6) tick();
      Prescale  = 6'd8;
      stop_bits = 1'b1;
      wait_idle("presc", 600);
      add_frame(8'hC3, 1'b0, 1'b0, 1'b0, 4);
      add_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
      check_log("presc");

      // reset during data bit 1 of the second of three queued frames
      Prescale   = 6'd2;
      stop_bits  = 1'b0;
      P_DATA     = 8'hAA;
      Data_Valid = 1'b1;
      tick();
      P_DATA     = 8'h55;
      tick();
      P_DATA     = 8'hF0;
      tick();
      Data_Valid = 1'b0;
      check("rst_level_queued", fifo_level, 2);
      repeat (23) tick();
      check("pre_rst_tx", TX_OUT, 0);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_level", fifo_level, 1);
      #1 RST = 1'b1;
      #1;
      check("async_rst_tx", TX_OUT, 1);
      check("async_rst_busy", busy, 0);
      check("async_rst_level", fifo_level, 0);
      check("async_rst_ready", ready, 1);
      tick();
      RST = 1'b0;
      log_q.delete();
      repeat (60) tick();
      nz = 0;
      nb = 0;
      foreach (log_q[i]) begin
         if (!log_q[i][0]) nz++;
         if (log_q[i][1]) nb++;
      end
      check("post_rst_no_start", nz, 0);
      check("post_rst_no_busy", nb, 0);
      check("post_rst_level", fifo_level, 0);
      rec = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
